// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared fetch-side constants, bus widths and FSM state type
package inst_fetch_pkg;
  localparam int InstAddressBus = 32;
  localparam int InstDataBus = 32;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic ResetEnable = 1'b1;
  localparam logic BranchEnable = 1'b1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_e;
endpackage

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo: 2-entry in-order {pc, inst} buffer; entry 0 is always the head
module fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int PC_W = InstAddressBus,
  parameter int D_W = InstDataBus
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [PC_W-1:0] push_pc,
  input  logic [D_W-1:0]  push_inst,
  output logic [1:0]      count,
  output logic [PC_W-1:0] head_pc,
  output logic [D_W-1:0]  head_inst
);
  localparam int W = PC_W + D_W;
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] count_q, count_d;
  logic wr1;
  always_comb begin
    wr1 = (count_q - {1'b0, pop}) != 2'd0;
    e0_d = (push && !wr1) ? {push_pc, push_inst} : pop ? e1_q : e0_q;
    e1_d = (push && wr1) ? {push_pc, push_inst} : e1_q;
    count_d = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      e0_q <= '0;
      e1_q <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      count_q <= count_d;
    end
  end
  assign count = count_q;
  assign {head_pc, head_inst} = e0_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC generation, credit-limited req/gnt/rvalid fetch and IF/ID presentation
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W = InstAddressBus,
  parameter int DATA_W = InstDataBus,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(inst_fetch_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_inst
);
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, issued_pc_q, issued_pc_d;
  logic out_q, out_d, discard_q, discard_d, req_q;
  logic branch, fire, resp, push, pop, credit;
  logic [1:0] count, cnt_nx;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_inst;
  assign branch = branch_flag == BranchEnable;
  assign fire = req_q & imem_gnt;
  assign resp = out_q & imem_rvalid;
  assign if_valid = count != 2'd0;
  assign pop = if_valid & !stall & !branch;
  assign push = resp & !discard_q & !branch;
  assign cnt_nx = branch ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
  always_comb begin
    out_d = fire ? 1'b1 : resp ? 1'b0 : out_q;
    // a response still in flight after a redirect belongs to the old path
    discard_d = branch ? ((out_q & !resp) | fire) : resp ? 1'b0 : discard_q;
    fetch_pc_d = branch ? (branch_target & ~ADDR_W'(3)) : fire ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
    issued_pc_d = fire ? fetch_pc_q : issued_pc_q;
    credit = ({1'b0, cnt_nx} + {2'b00, out_d}) < 3'd2;
    state_d = branch ? (out_d ? WAIT : REQ)
            : (state_q == IDLE) ? (credit ? REQ : IDLE)
            : (state_q == REQ) ? (fire ? WAIT : REQ)
            : resp ? (credit ? REQ : IDLE) : WAIT;
  end
  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      fetch_pc_q <= RESET_PC;
      issued_pc_q <= RESET_PC;
      out_q <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= state_d == REQ;
      fetch_pc_q <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      out_q <= out_d;
      discard_q <= discard_d;
    end
  end
  fetch_fifo #(.PC_W(ADDR_W), .D_W(DATA_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(branch),
    .push_pc(issued_pc_q),
    .push_inst(imem_rdata),
    .count(count),
    .head_pc(head_pc),
    .head_inst(head_inst)
  );
  assign imem_req = req_q;
  assign imem_addr = fetch_pc_q;
  assign if_pc = if_valid ? head_pc : '0;
  assign if_inst = if_valid ? head_inst : DATA_W'(ZeroWord);
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed checks of inst_fetch against a one-outstanding memory model
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic stall = 1'b0;
  logic branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic if_valid;
  logic [31:0] if_pc, if_inst;
  logic gnt_en = 1'b1;
  logic hold_rsp = 1'b0;
  logic pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_gnt = imem_req & gnt_en;
  assign imem_rvalid = pend & !hold_rsp;
  assign imem_rdata = pend_addr ^ 32'hA5A5_0000;

  always @(posedge clk) begin
    if ((imem_req & imem_gnt) === 1'b1) begin
      pend <= 1'b1;
      pend_addr <= imem_addr;
    end else if (imem_rvalid === 1'b1) begin
      pend <= 1'b0;
    end
  end

  inst_fetch dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .stall(stall),
    .branch_flag(branch_flag),
    .branch_target(branch_target),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_inst(if_inst)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, if_valid}, {31'b0, v});
    chk({tag, "_pc"}, if_pc, v ? pc : 32'h0);
    chk({tag, "_inst"}, if_inst, v ? (pc ^ 32'hA5A5_0000) : 32'h0);
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk_out("rst", 1'b0, 32'h0);

    // zero-wait streaming: req every 2 cycles, valid on odd cycles from 3
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("t1_req", {31'b0, imem_req}, 32'(k % 2));
      chk_out("t1", (k >= 3) && (k % 2 == 1), 32'((k - 3) * 2));
    end

    // stall from first valid: two entries buffered, requests stop, head holds
    do_reset();
    step();
    step();
    step();
    chk_out("t2_first", 1'b1, 32'h0);
    stall = 1'b1;
    for (int k = 4; k <= 13; k++) begin
      step();
      chk("t2_req", {31'b0, imem_req}, 32'd0);
      chk_out("t2_hold", 1'b1, 32'h0);
    end
    stall = 1'b0;
    step();
    chk_out("t2_rel1", 1'b1, 32'h4);
    chk("t2_req_rel", {31'b0, imem_req}, 32'd1);
    chk("t2_addr_rel", imem_addr, 32'h8);
    step();
    chk_out("t2_rel2", 1'b0, 32'h0);
    step();
    chk_out("t2_rel3", 1'b1, 32'h8);

    // delayed gnt on pc 8, then branch while pc 8 is outstanding
    do_reset();
    for (int k = 1; k <= 5; k++) step();
    chk_out("t3_pc4", 1'b1, 32'h4);
    gnt_en = 1'b0;
    for (int k = 6; k <= 8; k++) begin
      step();
      chk("t3_req_hold", {31'b0, imem_req}, 32'd1);
      chk("t3_addr_hold", imem_addr, 32'h8);
    end
    gnt_en = 1'b1;
    hold_rsp = 1'b1;
    step();
    chk("t3_req_after_gnt", {31'b0, imem_req}, 32'd0);
    branch_flag = 1'b1;
    branch_target = 32'h0000_0100;
    step();
    branch_flag = 1'b0;
    hold_rsp = 1'b0;
    chk_out("t3_flush", 1'b0, 32'h0);
    step();
    chk_out("t3_drop", 1'b0, 32'h0);
    chk("t3_req_tgt", {31'b0, imem_req}, 32'd1);
    chk("t3_addr_tgt", imem_addr, 32'h100);
    step();
    step();
    chk_out("t3_pc100", 1'b1, 32'h100);
    step();
    step();
    chk_out("t3_pc104", 1'b1, 32'h104);

    // branch + stall + rvalid in one cycle: data dropped, misaligned target aligned
    step();
    chk("t4_rvalid_pending", {31'b0, imem_rvalid}, 32'd1);
    branch_flag = 1'b1;
    branch_target = 32'h0000_0103;
    stall = 1'b1;
    step();
    branch_flag = 1'b0;
    stall = 1'b0;
    chk_out("t4_drop", 1'b0, 32'h0);
    chk("t4_req", {31'b0, imem_req}, 32'd1);
    chk("t4_addr", imem_addr, 32'h100);
    step();
    step();
    chk_out("t4_pc100", 1'b1, 32'h100);

    // branch coinciding with gnt, then PC wrap FFFF_FFFC -> 0
    branch_flag = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    branch_flag = 1'b0;
    chk_out("t5_flush", 1'b0, 32'h0);
    step();
    chk_out("t5_drop", 1'b0, 32'h0);
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    step();
    step();
    chk_out("t5_top", 1'b1, 32'hFFFF_FFFC);
    chk("t5_addr_wrap", imem_addr, 32'h0);
    step();
    step();
    chk_out("t5_wrap", 1'b1, 32'h0);

    // reset while a response is outstanding; late rvalid must be ignored
    hold_rsp = 1'b1;
    step();
    chk("t6_req_issued", {31'b0, imem_req}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    hold_rsp = 1'b0;
    chk("t6_req_rst", {31'b0, imem_req}, 32'd0);
    chk("t6_addr_rst", imem_addr, 32'h0);
    chk_out("t6_rst", 1'b0, 32'h0);
    step();
    chk("t6_req_first", {31'b0, imem_req}, 32'd1);
    chk("t6_addr_first", imem_addr, 32'h0);
    chk_out("t6_ignored", 1'b0, 32'h0);
    step();
    chk_out("t6_wait", 1'b0, 32'h0);
    step();
    chk_out("t6_pc0", 1'b1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch unit. It generates the PC, issues requests to the instruction memory over a req/gnt/rvalid handshake, and presents fetched {pc, inst} pairs to the IF/ID pipeline register.
- It drives the if_pc/if_inst inputs of the IF/ID stage and inserts bubbles (inst = zero word = MIPS nop) when no instruction is available.
- It honours the downstream stall and single-cycle branch redirects from the ID stage.

Parameters:
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction word width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- imem_req  out  1  request valid; held until imem_gnt.
- imem_addr  out  ADDR_W  request address; word aligned.
- imem_gnt  in  1  memory accepts the request this cycle (req & gnt = issued).
- imem_rvalid  in  1  read data valid; at most one response per issued request, in order.
- imem_rdata  in  DATA_W  instruction word.
- stall  in  1  downstream cannot accept this cycle.
- branch_flag  in  1  single-cycle redirect pulse.
- branch_target  in  ADDR_W  redirect address, valid with branch_flag.
- if_valid  out  1  if_pc/if_inst hold a real instruction.
- if_pc  out  ADDR_W  PC of the presented instruction; zero when !if_valid.
- if_inst  out  DATA_W  presented instruction; zero word when !if_valid.

Behaviour:
- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0, fetch_pc=RESET_PC, buffer count=0, outstanding=0, discard=0, state=IDLE.
- Rising-edge reset in the middle of an operation clears all state identically. Any imem_rvalid arriving while outstanding=0 is ignored.
- Buffer: 2-entry in-order FIFO of {pc, inst}. The head drives the outputs combinationally from registers. if_valid = (count != 0).
- Pop: when if_valid & !stall.
- Credit rule: a new request may be issued only when count + outstanding < 2, after accounting for a pop in the same cycle.
- FSM states:
  - IDLE: imem_req=0. Go to REQ when the credit rule permits.
  - REQ: imem_req=1, imem_addr=fetch_pc, held stable until gnt. On gnt: outstanding=1, fetch_pc += 4, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid:
    - discard=0: push {issued pc, rdata}.
    - discard=1: drop the word and clear discard.
    - In either case outstanding=0, then go to REQ if credit permits, else IDLE.
- Latency: the earliest request goes out in the first cycle after rst deasserts. With zero-wait memory (gnt same cycle, rvalid next cycle), if_valid rises 2 cycles after the first req cycle. Steady-state throughput is 1 instruction per 2 cycles.
- PC arithmetic: fetch_pc += 4, modulo 2^ADDR_W (32'hFFFF_FFFC wraps to 0). Bits [1:0] of branch_target are ignored (forced to 0).
- Branch (branch_flag=1), effective in the same cycle:
  - Flush the buffer (count=0; if_valid=0 next cycle). Any pop that cycle is cancelled.
  - fetch_pc = target.
  - If a response is outstanding, or a gnt occurs this cycle, set discard=1.
  - In REQ without gnt: imem_addr changes to the target next cycle and imem_req stays 1. This is the only allowed address change while req is pending.
  - State goes to REQ if outstanding will be 0, else WAIT.
- Branch and stall in the same cycle: branch wins.
- Branch while discard is already set: the target is updated; only one discard exists, since at most one request is outstanding.
- Branch and rvalid in the same cycle: the response is dropped.
- Stall with a full buffer: no requests are issued and the outputs hold stable.

Decomposition:
- Shared define file holds: ZeroWord, ResetEnable, InstAddressBus, InstDataBus, a new RESET_PC constant, and BranchEnable. Same file used by the IF/ID stage.
- One sub-module, fetch_fifo: 2-entry {pc, inst} FIFO with push, pop, flush, count, and head outputs.
- The FSM, credit logic and PC arithmetic stay in inst_fetch.

Test Plan:
- Reset release with a zero-wait memory returning rdata = addr ^ 32'hA5A5_0000, stall=0 -> sequence if_pc = 0, 4, 8, 12, each with if_valid=1 and matching inst; a new req every 2 cycles.
- Hold stall=1 for 10 cycles from the first if_valid -> exactly 2 instructions buffered, imem_req stays 0, outputs stable at pc 0. On release -> pc 0, 4, 8 delivered in order, none skipped or duplicated.
- gnt delayed 3 cycles on the req for pc 8 -> imem_addr stays at 8 and imem_req stays high until gnt. Then branch_flag with target 32'h100 while the response for 8 is outstanding -> pc 8 dropped, buffer flushed, next if_pc = 32'h100, then 32'h104.
- Branch with target 32'h0000_0103 in the same cycle as stall=1 and rvalid -> rvalid data dropped, next issued imem_addr = 32'h100.
- Set fetch_pc via branch target 32'hFFFF_FFFC -> fetched pcs are FFFF_FFFC then 0000_0000.
- Assert rst for 1 cycle while a response is outstanding, then memory delivers rvalid -> rvalid ignored, if_valid=0, first new req at RESET_PC.
